// File: rtl/bsg_ds_rx_pkg.sv
// Shared width helpers and parameter checks for the downstream rx channel.
package bsg_ds_rx_pkg;

  function automatic int core_w_f(input int nc, input int cw, input int beats);
    return nc * cw * beats;
  endfunction

  function automatic int ptr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int tok_w_f(input int decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

  function automatic bit params_ok_f(input int depth, input int beats,
                                     input int decim);
    return (depth > 0) && ((depth & (depth - 1)) == 0) &&
           (beats > 0) && (depth >= beats) &&
           (decim > 0) && ((decim % beats) == 0);
  endfunction

endpackage

// File: rtl/bsg_ds_rx_chan_fifo.sv
// Per-channel beat FIFO: one beat in per cycle, BEATS beats out per pop.
module bsg_ds_rx_chan_fifo
  import bsg_ds_rx_pkg::*;
#(
  parameter  int CH_W  = 8,
  parameter  int DEPTH = 32,
  parameter  int BEATS = 2,
  localparam int PW    = ptr_w_f(DEPTH),
  localparam int OW    = occ_w_f(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [CH_W-1:0]       data_i,
  input  logic                  pop_i,
  output logic [OW-1:0]         occ_o,
  output logic [BEATS*CH_W-1:0] rd_data_o
);

  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);
  localparam logic [OW-1:0] BEATS_OCC = OW'(BEATS);

  logic [CH_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            wr_en;

  // a pop in the same cycle frees room for the incoming beat
  assign wr_en = push_i && !((occ_q == DEPTH_OCC) && !pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      occ_d    = occ_d + OW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(BEATS);
      occ_d    = occ_d - BEATS_OCC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_rd
    assign rd_data_o[b*CH_W +: CH_W] = mem_q[rd_ptr_q + PW'(b)];
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/bsg_downstream_rx_multi.sv
// Multi-channel downstream rx: beat FIFOs, word assembly, credit tokens.
// Define BSG_DS_RX_OVERFLOW_CHECK_EN for sticky per-channel overflow flags.
module bsg_downstream_rx_multi
  import bsg_ds_rx_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int CH_W        = 8,
  parameter  int BEATS       = 2,
  parameter  int DEPTH       = 32,
  parameter  int TOKEN_DECIM = 4,
  localparam int CORE_W      = core_w_f(NUM_CH, CH_W, BEATS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      io_valid_i,
  input  logic [NUM_CH*CH_W-1:0] io_data_i,
  output logic [NUM_CH-1:0]      io_token_o,
  output logic [CORE_W-1:0]      core_data_o,
  output logic                   core_valid_o,
  input  logic                   core_yumi_i,
  output logic [NUM_CH-1:0]      overflow_o
);

  localparam int OW  = occ_w_f(DEPTH);
  localparam int TW  = tok_w_f(TOKEN_DECIM);
  localparam int TSW = TW + 1;
  localparam logic [OW-1:0]  BEATS_OCC = OW'(BEATS);
  localparam logic [OW-1:0]  DEPTH_OCC = OW'(DEPTH);
  localparam logic [TSW-1:0] BEATS_T   = TSW'(BEATS);
  localparam logic [TSW-1:0] DECIM_T   = TSW'(TOKEN_DECIM);

  if (!params_ok_f(DEPTH, BEATS, TOKEN_DECIM)) begin : g_bad_params
    $error("bsg_downstream_rx_multi: illegal DEPTH/BEATS/TOKEN_DECIM");
  end

  logic [OW-1:0]          occ     [NUM_CH];
  logic [BEATS*CH_W-1:0]  rd_data [NUM_CH];
  logic [NUM_CH-1:0]      have_beats;
  logic                   ready, load;
  logic [CORE_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic [TW-1:0]          tok_cnt_q [NUM_CH];
  logic [TW-1:0]          tok_cnt_d [NUM_CH];
  logic [TSW-1:0]         tok_sum;
  logic [NUM_CH-1:0]      token_q, token_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bsg_ds_rx_chan_fifo #(
      .CH_W  (CH_W),
      .DEPTH (DEPTH),
      .BEATS (BEATS)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (io_valid_i[c]),
      .data_i    (io_data_i[c*CH_W +: CH_W]),
      .pop_i     (load),
      .occ_o     (occ[c]),
      .rd_data_o (rd_data[c])
    );
    assign have_beats[c] = (occ[c] >= BEATS_OCC);
  end

  assign ready = &have_beats;
  assign load  = ready && (!valid_q || core_yumi_i);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
      for (int b = 0; b < BEATS; b++)
        for (int c = 0; c < NUM_CH; c++)
          data_d[(b*NUM_CH+c)*CH_W +: CH_W] = rd_data[c][b*CH_W +: CH_W];
    end else if (core_yumi_i) begin
      valid_d = 1'b0;
    end
  end

  // TOKEN_DECIM is a multiple of BEATS, so the sum lands exactly on it
  always_comb begin
    token_d = '0;
    tok_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tok_cnt_d[c] = tok_cnt_q[c];
      if (load) begin
        tok_sum = {1'b0, tok_cnt_q[c]} + BEATS_T;
        if (tok_sum >= DECIM_T) begin
          tok_cnt_d[c] = '0;
          token_d[c]   = 1'b1;
        end else begin
          tok_cnt_d[c] = tok_sum[TW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      token_q <= '0;
      for (int c = 0; c < NUM_CH; c++) tok_cnt_q[c] <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      token_q <= token_d;
      for (int c = 0; c < NUM_CH; c++) tok_cnt_q[c] <= tok_cnt_d[c];
    end
  end

`ifdef BSG_DS_RX_OVERFLOW_CHECK_EN
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    for (int c = 0; c < NUM_CH; c++)
      if (io_valid_i[c] && (occ[c] == DEPTH_OCC) && !load)
        ovf_d[c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = '0;
`endif

  assign core_data_o  = data_q;
  assign core_valid_o = valid_q;
  assign io_token_o   = token_q;

endmodule

// File: tb/tb_bsg_downstream_rx_multi.sv
// Randomized bench for bsg_downstream_rx_multi against a queue-based model.
// Honours BSG_DS_RX_OVERFLOW_CHECK_EN when predicting overflow_o.
module tb_bsg_downstream_rx_multi;

  localparam int NUM_CH      = 2;
  localparam int CH_W        = 8;
  localparam int BEATS       = 2;
  localparam int DEPTH       = 32;
  localparam int TOKEN_DECIM = 4;
  localparam int CORE_W      = NUM_CH * CH_W * BEATS;
  localparam int DW          = NUM_CH * CH_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] io_valid_i;
  logic [DW-1:0]     io_data_i;
  logic [NUM_CH-1:0] io_token_o;
  logic [CORE_W-1:0] core_data_o;
  logic              core_valid_o;
  logic              core_yumi_i;
  logic [NUM_CH-1:0] overflow_o;

  bsg_downstream_rx_multi #(
    .NUM_CH      (NUM_CH),
    .CH_W        (CH_W),
    .BEATS       (BEATS),
    .DEPTH       (DEPTH),
    .TOKEN_DECIM (TOKEN_DECIM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_valid_i   (io_valid_i),
    .io_data_i    (io_data_i),
    .io_token_o   (io_token_o),
    .core_data_o  (core_data_o),
    .core_valid_o (core_valid_o),
    .core_yumi_i  (core_yumi_i),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CH_W-1:0]   mq [NUM_CH][$];
  logic              m_valid;
  logic [CORE_W-1:0] m_data;
  logic [NUM_CH-1:0] m_token;
  logic [NUM_CH-1:0] m_ovf;
  int                m_loads;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_token = '0;
    m_ovf   = '0;
    m_loads = 0;
  endtask

  // one clock edge of the channel, described in terms of queued beats
  task automatic model_step(input logic [NUM_CH-1:0] v,
                            input logic [DW-1:0] d, input logic y);
    bit                rdy = 1'b1;
    logic [CORE_W-1:0] w = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (mq[c].size() < BEATS) rdy = 1'b0;
    if (rdy && (!m_valid || y)) begin
      for (int b = 0; b < BEATS; b++)
        for (int c = 0; c < NUM_CH; c++)
          w[(b*NUM_CH+c)*CH_W +: CH_W] = mq[c].pop_front();
      m_data  = w;
      m_valid = 1'b1;
      m_loads++;
      m_token = (((m_loads * BEATS) % TOKEN_DECIM) == 0) ? '1 : '0;
    end else begin
      m_token = '0;
      if (y) m_valid = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++)
      if (v[c]) begin
        if (mq[c].size() >= DEPTH) m_ovf[c] = 1'b1;
        else mq[c].push_back(d[c*CH_W +: CH_W]);
      end
  endtask

  task automatic check_all();
    check("valid", 64'(core_valid_o), 64'(m_valid));
    check("data", 64'(core_data_o), 64'(m_data));
    check("token", 64'(io_token_o), 64'(m_token));
`ifdef BSG_DS_RX_OVERFLOW_CHECK_EN
    check("overflow", 64'(overflow_o), 64'(m_ovf));
`else
    check("overflow", 64'(overflow_o), 64'(0));
`endif
  endtask

  // called at a negedge; returns at the following negedge
  task automatic cycle(input logic [NUM_CH-1:0] v, input logic [DW-1:0] d,
                       input logic y);
    io_valid_i  = v;
    io_data_i   = d;
    core_yumi_i = y;
    @(posedge clk);
    model_step(v, d, y);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n, input int p0, input int p1, input int py);
    logic [NUM_CH-1:0] v;
    logic [DW-1:0]     d;
    logic              y;
    for (int i = 0; i < n; i++) begin
      v[0] = ($urandom_range(99) < p0);
      v[1] = ($urandom_range(99) < p1);
      d    = DW'($urandom());
      y    = m_valid && ($urandom_range(99) < py);
      cycle(v, d, y);
    end
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_valid"}, 64'(core_valid_o), 64'(0));
    check({tag, "_data"}, 64'(core_data_o), 64'(0));
    check({tag, "_token"}, 64'(io_token_o), 64'(0));
    check({tag, "_ovf"}, 64'(overflow_o), 64'(0));
  endtask

  initial begin
    rst_n       = 1'b0;
    io_valid_i  = '0;
    io_data_i   = '0;
    core_yumi_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outputs_check("rst");
    rst_n = 1'b1;

    // two beats per channel, word appears one edge after the last push
    cycle(2'b11, {8'hA1, 8'h11}, 1'b0);
    cycle(2'b11, {8'hB2, 8'h22}, 1'b0);
    check("t1_pre_valid", 64'(core_valid_o), 64'(0));
    cycle(2'b00, '0, 1'b0);
    check("t1_word", 64'(core_data_o), 64'(32'hB222A111));
    check("t1_valid", 64'(core_valid_o), 64'(1));
    cycle(2'b00, '0, 1'b1);
    check("t1_drop", 64'(core_valid_o), 64'(0));

    run(300, 60, 60, 70);
    run(80, 100, 100, 0);
    run(100, 40, 40, 100);
    run(40, 50, 0, 100);
    run(10, 0, 100, 100);
    run(200, 90, 90, 90);
    run(200, 100, 100, 100);

    // asynchronous reset in the middle of a pending word
    run(6, 100, 100, 0);
    #2 rst_n = 1'b0;
    #1 reset_outputs_check("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(2'b11, {8'h5A, 8'h3C}, 1'b0);
    cycle(2'b11, {8'h96, 8'h0F}, 1'b0);
    cycle(2'b00, '0, 1'b0);
    check("t6_word", 64'(core_data_o), 64'(32'h960F5A3C));

    run(200, 70, 70, 50);
    run(60, 100, 100, 0);
    run(150, 20, 20, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
